axis_width_upsizer: RTL and testbench

- AXI-Stream narrow-to-wide packer that sits directly downstream of the SRL FIFO and consumes its 8-bit output stream.
- Packs RATIO consecutive input beats into one wide output beat, with per-lane tkeep.
- A frame's tlast closes a partial word early, so frames never merge across an output beat.
- Feeds wide datapath stages such as DMA write or wide-bus packet logic.

---
 rtl/axis_width_upsizer.sv | 119 +++++++++++
 tb/tb_axis_width_upsizer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_upsizer.sv
// AXI-Stream narrow-to-wide packer: RATIO input lanes -> one output word with per-lane tkeep.
// Latency: the completing input beat (last lane or tlast) shows on output_axis_tvalid 1 clock later.
// Backpressure: input_axis_tready = ~output_axis_tvalid | output_axis_tready; a stalled output word stops input.
// Optional: define AXIS_WIDTH_UPSIZER_FRAME_COUNT_EN to add a 16-bit wrapping frame_count output.
module axis_width_upsizer #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int RATIO            = 4   // must be >= 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUT_DATA_WIDTH-1:0]       input_axis_tdata,
  input  logic                              input_axis_tvalid,
  output logic                              input_axis_tready,
  input  logic                              input_axis_tlast,
  input  logic                              input_axis_tuser,
  output logic [INPUT_DATA_WIDTH*RATIO-1:0] output_axis_tdata,
  output logic [RATIO-1:0]                  output_axis_tkeep,
  output logic                              output_axis_tvalid,
  input  logic                              output_axis_tready,
  output logic                              output_axis_tlast,
  output logic                              output_axis_tuser
`ifdef AXIS_WIDTH_UPSIZER_FRAME_COUNT_EN
  ,
  output logic [15:0]                       frame_count
`endif
);

  localparam int OUT_W = INPUT_DATA_WIDTH * RATIO;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Accumulator: lanes gathered so far for the word being built.
  logic [OUT_W-1:0] acc_data;
  logic [RATIO-1:0] acc_keep;
  logic             acc_user;
  logic [IDX_W-1:0] lane_idx;

  // Accumulator with the current input beat merged into lane[lane_idx].
  logic [OUT_W-1:0] merged_data;
  logic [RATIO-1:0] merged_keep;
  logic             merged_user;

  logic in_fire;
  logic out_fire;
  logic word_done;

  // Ready depends only on the output register state and downstream ready.
  assign input_axis_tready = ~output_axis_tvalid | output_axis_tready;
  assign in_fire           = input_axis_tvalid & input_axis_tready;
  assign out_fire          = output_axis_tvalid & output_axis_tready;
  // A word closes on the last lane or early on tlast, so frames never share a word.
  assign word_done         = in_fire & (input_axis_tlast | (lane_idx == LAST_IDX));

  // Merge the incoming beat into its lane; lanes not yet written stay zero.
  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    merged_user = acc_user | input_axis_tuser;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_idx == IDX_W'(k)) begin
        merged_data[k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = input_axis_tdata;
        merged_keep[k]                                      = 1'b1;
      end
    end
  end

  // Accumulator: store non-completing beats, clear once a word is handed to the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_user <= 1'b0;
      lane_idx <= '0;
    end else if (in_fire) begin
      if (word_done) begin
        acc_data <= '0;
        acc_keep <= '0;
        acc_user <= 1'b0;
        lane_idx <= '0;
      end else begin
        acc_data <= merged_data;
        acc_keep <= merged_keep;
        acc_user <= merged_user;
        lane_idx <= lane_idx + IDX_W'(1);
      end
    end
  end

  // Output register: a new word wins over the clear, giving back-to-back words at full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_axis_tvalid <= 1'b0;
      output_axis_tdata  <= '0;
      output_axis_tkeep  <= '0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
    end else if (word_done) begin
      output_axis_tvalid <= 1'b1;
      output_axis_tdata  <= merged_data;
      output_axis_tkeep  <= merged_keep;
      output_axis_tlast  <= input_axis_tlast;
      output_axis_tuser  <= merged_user;
    end else if (out_fire) begin
      output_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_WIDTH_UPSIZER_FRAME_COUNT_EN
  // Count frames leaving the block; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= 16'h0000;
    end else if (out_fire && output_axis_tlast) begin
      frame_count <= frame_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Self-checking bench for axis_width_upsizer (INPUT_DATA_WIDTH=8, RATIO=4).
// Directed vector table, hand sequences for reset corners, then random traffic vs a frame-level model.
// Frame counter checks are compiled only when AXIS_WIDTH_UPSIZER_FRAME_COUNT_EN is defined.
module tb_axis_width_upsizer;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int OW = W * R;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_dat;
  logic          in_vld;
  logic          in_rdy;
  logic          in_last;
  logic          in_user;
  logic [OW-1:0] out_dat;
  logic [R-1:0]  out_keep;
  logic          out_vld;
  logic          out_rdy;
  logic          out_last;
  logic          out_user;
`ifdef AXIS_WIDTH_UPSIZER_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  axis_width_upsizer #(.INPUT_DATA_WIDTH(W), .RATIO(R)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_dat),
    .input_axis_tvalid  (in_vld),
    .input_axis_tready  (in_rdy),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_dat),
    .output_axis_tkeep  (out_keep),
    .output_axis_tvalid (out_vld),
    .output_axis_tready (out_rdy),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user)
`ifdef AXIS_WIDTH_UPSIZER_FRAME_COUNT_EN
    ,
    .frame_count        (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Directed vector: inputs for one cycle, ready expected before the edge, outputs expected after it.
  typedef struct {
    logic          vld;
    logic [W-1:0]  dat;
    logic          last;
    logic          user;
    logic          ordy;
    logic          e_irdy;
    logic          e_ovld;
    logic [OW-1:0] e_dat;
    logic [R-1:0]  e_keep;
    logic          e_last;
    logic          e_user;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vld, input logic [7:0] dat, input logic last, input logic user,
                     input logic ordy, input logic e_irdy, input logic e_ovld, input logic [31:0] e_dat,
                     input logic [3:0] e_keep, input logic e_last, input logic e_user);
    vec_t v;
    v.vld = vld; v.dat = dat; v.last = last; v.user = user; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_dat = e_dat; v.e_keep = e_keep;
    v.e_last = e_last; v.e_user = e_user;
    tbl.push_back(v);
  endtask

  // Frame-level reference: words are built from accepted beats by the packing rules alone.
  typedef struct {
    logic [OW-1:0] dat;
    logic [R-1:0]  keep;
    logic          last;
    logic          user;
  } word_t;

  word_t         exp_q[$];
  logic [OW-1:0] m_dat;
  logic [R-1:0]  m_keep;
  logic          m_user;
  int            m_n;
  int            words_seen;

  task automatic model_beat(input logic [W-1:0] d, input logic l, input logic u);
    word_t w;
    m_dat[m_n*W +: W] = d;
    m_keep[m_n]       = 1'b1;
    m_user            = m_user | u;
    m_n++;
    if (m_n == R || l) begin
      w.dat = m_dat; w.keep = m_keep; w.last = l; w.user = m_user;
      exp_q.push_back(w);
      m_dat = '0; m_keep = '0; m_user = 1'b0; m_n = 0;
    end
  endtask

  // One random-phase cycle: compare any output handshake, feed accepted input to the model, clock.
  task automatic rnd_cycle();
    logic  a_in;
    logic  a_out;
    word_t w;
    #1;
    a_in  = in_vld & in_rdy;
    a_out = out_vld & out_rdy;
    if (a_out) begin
      if (exp_q.size() == 0) begin
        check("rnd_unexpected_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        words_seen++;
        check($sformatf("rnd_word%0d", words_seen), {out_dat, out_keep, out_last, out_user},
              {w.dat, w.keep, w.last, w.user});
      end
    end
    if (a_in) model_beat(in_dat, in_last, in_user);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_vld = 1'b0; in_dat = '0; in_last = 1'b0; in_user = 1'b0;
  endtask

  // Drive one beat with downstream ready; always accepted since ready is then 1.
  task automatic send(input logic [7:0] d, input logic l);
    in_vld = 1'b1; in_dat = d; in_last = l; in_user = 1'b0; out_rdy = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_vld"},  out_vld,  0);
    check({tag, "_dat"},  out_dat,  0);
    check({tag, "_keep"}, out_keep, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_user"}, out_user, 0);
  endtask

  initial begin
    bit hold;
    rst = 1'b1; out_rdy = 1'b0;
    idle_inputs();
    m_dat = '0; m_keep = '0; m_user = 1'b0; m_n = 0; words_seen = 0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    check("reset_in_rdy", in_rdy, 1);
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    //   vld dat  last user ordy | irdy ovld dat            keep last user
    add(1, 8'h11, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h22, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h33, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h44, 1, 0, 1,   1, 1, 32'h44332211,   4'hF, 1, 0);
    add(1, 8'hAA, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'hBB, 1, 0, 1,   1, 1, 32'h0000BBAA,   4'h3, 1, 0);
    add(1, 8'hCC, 1, 1, 1,   1, 1, 32'h000000CC,   4'h1, 1, 1);  // back-to-back 1-beat frame
    add(0, 8'h00, 0, 0, 0,   0, 1, 32'h000000CC,   4'h1, 1, 1);  // stalled: held
    add(1, 8'hDD, 0, 0, 0,   0, 1, 32'h000000CC,   4'h1, 1, 1);  // input blocked
    add(1, 8'hDD, 1, 0, 1,   1, 1, 32'h000000DD,   4'h1, 1, 0);  // resume same cycle
    add(0, 8'h00, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h01, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);  // tuser aggregation
    add(1, 8'h02, 0, 1, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h03, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h04, 0, 0, 1,   1, 1, 32'h04030201,   4'hF, 0, 1);
    add(1, 8'h05, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h06, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h07, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);
    add(1, 8'h08, 1, 0, 1,   1, 1, 32'h08070605,   4'hF, 1, 0);
    add(0, 8'h00, 0, 0, 1,   1, 0, 32'h0,          4'h0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      in_vld = tbl[i].vld; in_dat = tbl[i].dat; in_last = tbl[i].last;
      in_user = tbl[i].user; out_rdy = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d_in_rdy", i), in_rdy, tbl[i].e_irdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_vld", i), out_vld, tbl[i].e_ovld);
      if (tbl[i].e_ovld) begin
        check($sformatf("vec%0d_out_word", i), {out_dat, out_keep, out_last, out_user},
              {tbl[i].e_dat, tbl[i].e_keep, tbl[i].e_last, tbl[i].e_user});
      end
    end
    idle_inputs();

    // ---------------- reset mid-word discards partial lanes ----------------
    send(8'h01, 0);
    send(8'h02, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("midrst");
    rst = 1'b0;
    send(8'h03, 0);
    send(8'h04, 0);
    send(8'h05, 0);
    send(8'h06, 1);
    check("midrst_word", {out_vld, out_dat, out_keep, out_last},
          {1'b1, 32'h06050403, 4'hF, 1'b1});
    @(posedge clk);
    #1;

    // ---------------- reset drops a pending stalled word ----------------
    send(8'hE1, 0);
    send(8'hE2, 1);
    out_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("pendrst_vld", out_vld, 0);
    rst = 1'b0;
    send(8'h5A, 1);
    check("pendrst_next", {out_vld, out_dat, out_keep}, {1'b1, 32'h0000005A, 4'h1});
    @(posedge clk);
    #1;

    // ---------------- random traffic vs frame model ----------------
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_vld  = ($urandom_range(0, 3) != 0);
        in_dat  = W'($urandom);
        in_last = ($urandom_range(0, 5) == 0);
        in_user = ($urandom_range(0, 7) == 0);
      end
      out_rdy = ($urandom_range(0, 2) != 0);
      #1;
      // a valid beat not taken this cycle must be presented unchanged next cycle
      hold = in_vld & ~in_rdy;
      rnd_cycle();
    end
    // close the trailing frame with downstream ready so it always completes
    out_rdy = 1'b1;
    in_vld = 1'b1; in_dat = 8'h7E; in_last = 1'b1; in_user = 1'b0;
    rnd_cycle();
    idle_inputs();
    repeat (4) rnd_cycle();
    check("rnd_queue_drained", exp_q.size(), 0);
    check("rnd_words_observed", (words_seen > 20), 1);

`ifdef AXIS_WIDTH_UPSIZER_FRAME_COUNT_EN
    // ---------------- frame counter ----------------
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("fc_reset", frame_count, 16'h0000);
    rst = 1'b0;
    send(8'h10, 1);
    for (int b = 0; b < 4; b++) send(8'(b), b == 3);
    for (int b = 0; b < 6; b++) send(8'(b), b == 5);
    repeat (2) @(posedge clk);
    #1;
    check("fc_three", frame_count, 16'd3);
    for (int f = 0; f < 65532; f++) send(8'h00, 1);
    repeat (2) @(posedge clk);
    #1;
    check("fc_max", frame_count, 16'hFFFF);
    send(8'h00, 1);
    repeat (2) @(posedge clk);
    #1;
    check("fc_wrap", frame_count, 16'h0000);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
